// File: rtl/tpm_port_sequencer_if.sv
// rtl/tpm_port_sequencer_if.sv - request, memory and response bundle for tpm_port_sequencer
interface tpm_port_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              port1_valid_in, port2_valid_in, port3_valid_in;
  logic              port1_we_in, port2_we_in, port3_we_in;
  logic [ADDR_W-1:0] port1_addr_in, port2_addr_in, port3_addr_in;
  logic [DATA_W-1:0] port1_wdata_in, port2_wdata_in, port3_wdata_in;
  logic              req_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        slot1_orig_id, slot2_orig_id, slot3_orig_id;
  logic [DATA_W-1:0] port1_rdata_out, port2_rdata_out, port3_rdata_out;
  logic              port1_rvalid_out, port2_rvalid_out, port3_rvalid_out;
  logic              batch_done;

  modport master (
    output port1_valid_in, port2_valid_in, port3_valid_in,
    output port1_we_in, port2_we_in, port3_we_in,
    output port1_addr_in, port2_addr_in, port3_addr_in,
    output port1_wdata_in, port2_wdata_in, port3_wdata_in,
    output mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  slot1_orig_id, slot2_orig_id, slot3_orig_id,
    input  port1_rdata_out, port2_rdata_out, port3_rdata_out,
    input  port1_rvalid_out, port2_rvalid_out, port3_rvalid_out,
    input  batch_done
  );

  modport slave (
    input  port1_valid_in, port2_valid_in, port3_valid_in,
    input  port1_we_in, port2_we_in, port3_we_in,
    input  port1_addr_in, port2_addr_in, port3_addr_in,
    input  port1_wdata_in, port2_wdata_in, port3_wdata_in,
    input  mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output slot1_orig_id, slot2_orig_id, slot3_orig_id,
    output port1_rdata_out, port2_rdata_out, port3_rdata_out,
    output port1_rvalid_out, port2_rvalid_out, port3_rvalid_out,
    output batch_done
  );
endinterface

// File: rtl/tpm_port_sequencer.sv
// rtl/tpm_port_sequencer.sv - round-robin batch sequencer of three request ports onto one memory port
module tpm_port_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input logic                 clk,
  input logic                 rst,
  tpm_port_sequencer_if.slave bus
);
  localparam logic [1:0] ORIG_PORT_1_ID = 2'd1;
  localparam logic [1:0] ORIG_PORT_2_ID = 2'd2;
  localparam logic [1:0] ORIG_PORT_3_ID = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t            r_state, w_nxt_state;
  logic              w_issue;

  // Port-indexed views of the live request inputs (index 0 = port1)
  logic [2:0]        w_v, w_we;
  logic [ADDR_W-1:0] w_addr [3];
  logic [DATA_W-1:0] w_wdata [3];

  // Captured batch, port-indexed; r_pend is rank-indexed (bit 0 = rank1)
  logic [1:0]        r_rot_ptr;
  logic [2:0]        r_pend, r_rd_mask, r_we;
  logic [ADDR_W-1:0] r_addr [3];
  logic [DATA_W-1:0] r_wdata [3];
  logic [1:0]        r_cur_port, r_rd_port;
  logic              r_rd_pend;

  // Registered outputs
  logic              r_ready, r_mem_en, r_mem_we, r_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_slot_id [3];
  logic [DATA_W-1:0] r_rdata [3];
  logic [2:0]        r_rvalid;

  // Slot selection
  logic [2:0]        w_in_mask, w_src_mask, w_sel_oh;
  logic [1:0]        w_sel_rank, w_sel_port;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] orig_id(input logic [1:0] p);
    case (p)
      2'd0:    return ORIG_PORT_1_ID;
      2'd1:    return ORIG_PORT_2_ID;
      default: return ORIG_PORT_3_ID;
    endcase
  endfunction

  assign w_v        = {bus.port3_valid_in, bus.port2_valid_in, bus.port1_valid_in};
  assign w_we       = {bus.port3_we_in, bus.port2_we_in, bus.port1_we_in};
  assign w_addr[0]  = bus.port1_addr_in;
  assign w_addr[1]  = bus.port2_addr_in;
  assign w_addr[2]  = bus.port3_addr_in;
  assign w_wdata[0] = bus.port1_wdata_in;
  assign w_wdata[1] = bus.port2_wdata_in;
  assign w_wdata[2] = bus.port3_wdata_in;

  // Pick the highest-ranked pending slot; in IDLE it comes straight from the inputs so the
  // first access can be registered on the capture edge itself
  always_comb begin
    w_in_mask[0] = w_v[r_rot_ptr];
    w_in_mask[1] = w_v[add_mod3(r_rot_ptr, 2'd1)];
    w_in_mask[2] = w_v[add_mod3(r_rot_ptr, 2'd2)];
    w_src_mask   = (r_state == S_IDLE) ? w_in_mask : r_pend;
    if (w_src_mask[0])      w_sel_rank = 2'd0;
    else if (w_src_mask[1]) w_sel_rank = 2'd1;
    else                    w_sel_rank = 2'd2;
    w_sel_oh   = 3'b001 << w_sel_rank;
    w_sel_port = add_mod3(r_rot_ptr, w_sel_rank);
    if (r_state == S_IDLE) begin
      w_sel_we    = w_we[w_sel_port];
      w_sel_addr  = w_addr[w_sel_port];
      w_sel_wdata = w_wdata[w_sel_port];
    end else begin
      w_sel_we    = r_we[w_sel_port];
      w_sel_addr  = r_addr[w_sel_port];
      w_sel_wdata = r_wdata[w_sel_port];
    end
  end

  // Next-state and issue decision
  always_comb begin
    w_nxt_state = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_in_mask) begin
          w_nxt_state = S_ISSUE;
          w_issue     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (|r_pend) w_issue = 1'b1;
        else         w_nxt_state = S_DRAIN;
      end
      S_DRAIN: w_nxt_state = S_RESP;
      S_RESP:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Batch capture, memory issue, read-data return and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rot_ptr    <= 2'd0;
      r_pend       <= 3'b000;
      r_rd_mask    <= 3'b000;
      r_we         <= 3'b000;
      r_cur_port   <= 2'd0;
      r_rd_port    <= 2'd0;
      r_rd_pend    <= 1'b0;
      r_ready      <= 1'b1;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done       <= 1'b0;
      r_rvalid     <= 3'b000;
      r_slot_id[0] <= ORIG_PORT_1_ID;
      r_slot_id[1] <= ORIG_PORT_2_ID;
      r_slot_id[2] <= ORIG_PORT_3_ID;
      for (int i = 0; i < 3; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_rdata[i] <= '0;
      end
    end else begin
      r_ready  <= (w_nxt_state == S_IDLE);
      r_mem_en <= w_issue;
      r_mem_we <= w_issue & w_sel_we;
      r_done   <= 1'b0;
      r_rvalid <= 3'b000;
      if (w_issue) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_cur_port  <= w_sel_port;
      end
      if (r_state == S_IDLE && w_issue) begin
        r_pend    <= w_in_mask & ~w_sel_oh;
        r_rd_mask <= w_v & ~w_we;
        r_we      <= w_we;
        for (int i = 0; i < 3; i++) begin
          r_addr[i]    <= w_addr[i];
          r_wdata[i]   <= w_wdata[i];
          r_slot_id[i] <= orig_id(add_mod3(r_rot_ptr, 2'(i)));
        end
      end else if (w_issue) begin
        r_pend <= r_pend & ~w_sel_oh;
      end
      // A read on the bus this cycle has its data on mem_rdata next cycle
      r_rd_pend <= r_mem_en & ~r_mem_we;
      r_rd_port <= r_cur_port;
      if (r_rd_pend) r_rdata[r_rd_port] <= bus.mem_rdata;
      if (r_state == S_DRAIN) begin
        r_done   <= 1'b1;
        r_rvalid <= r_rd_mask;
      end
      if (r_state == S_RESP) r_rot_ptr <= add_mod3(r_rot_ptr, 2'd1);
    end
  end

  assign bus.req_ready        = r_ready;
  assign bus.mem_en           = r_mem_en;
  assign bus.mem_we           = r_mem_we;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_wdata        = r_mem_wdata;
  assign bus.slot1_orig_id    = r_slot_id[0];
  assign bus.slot2_orig_id    = r_slot_id[1];
  assign bus.slot3_orig_id    = r_slot_id[2];
  assign bus.port1_rdata_out  = r_rdata[0];
  assign bus.port2_rdata_out  = r_rdata[1];
  assign bus.port3_rdata_out  = r_rdata[2];
  assign bus.port1_rvalid_out = r_rvalid[0];
  assign bus.port2_rvalid_out = r_rvalid[1];
  assign bus.port3_rvalid_out = r_rvalid[2];
  assign bus.batch_done       = r_done;
endmodule

// File: tb/tb_tpm_port_sequencer.sv
// tb/tb_tpm_port_sequencer.sv - scoreboard bench for tpm_port_sequencer
module tb_tpm_port_sequencer;
  localparam int DW = 8;
  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          first;
  } iss_t;

  typedef struct packed {
    logic [2:0]    rmask;
    logic [3*DW-1:0] rdata;
    logic [5:0]    slot;
  } bat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpm_port_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  tpm_port_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_en = 0;
  iss_t exp_iss[$];
  bat_t exp_bat[$];
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  int ref_rot = 0;

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      1:       return 8'hA1;
      2:       return 8'hA2;
      3:       return 8'hA3;
      5:       return 8'h5C;
      default: return DW'(i * 29 + 7);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory macro model: one access per cycle, read data one cycle later
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    bus.mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Monitor: pops expected issues and batch results as the DUT presents them
  initial begin
    iss_t e;
    bat_t b;
    logic [2:0] rv;
    logic [DW-1:0] rd [3];
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc++;
        rv = {bus.port3_rvalid_out, bus.port2_rvalid_out, bus.port1_rvalid_out};
        rd[0] = bus.port1_rdata_out;
        rd[1] = bus.port2_rdata_out;
        rd[2] = bus.port3_rdata_out;
        if (bus.mem_en) begin
          if (exp_iss.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue got addr=0x%0h expected no access t=%0t", bus.mem_addr, $time);
          end else begin
            e = exp_iss.pop_front();
            chk("issue_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("issue_we", 32'(bus.mem_we), 32'(e.we));
            if (e.we) chk("issue_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            if (!e.first) chk("issue_consecutive", 32'(cyc - last_en), 32'd1);
          end
          last_en = cyc;
        end else begin
          chk("mem_we_outside_issue", 32'(bus.mem_we), 32'd0);
        end
        if (bus.batch_done) begin
          if (exp_bat.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_batch_done got=1 expected=0 t=%0t", $time);
          end else begin
            b = exp_bat.pop_front();
            chk("done_latency", 32'(cyc - last_en), 32'd2);
            chk("rvalid_mask", 32'(rv), 32'(b.rmask));
            for (int p = 0; p < 3; p++)
              if (b.rmask[p]) chk($sformatf("port%0d_rdata", p + 1), 32'(rd[p]), 32'(b.rdata[p*DW +: DW]));
            chk("slot_ids", 32'({bus.slot3_orig_id, bus.slot2_orig_id, bus.slot1_orig_id}), 32'(b.slot));
            chk("issues_drained", 32'(exp_iss.size()), 32'd0);
          end
        end else if (rv != 3'b000) begin
          checks++;
          errors++;
          $display("FAIL rvalid_without_done got=%b expected=000 t=%0t", rv, $time);
        end
      end
    end
  end

  // Reference model: rank ports from the rotation pointer, replay accesses on a copy of memory
  task automatic push_model(input logic [2:0] v, input logic [2:0] we,
                            input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
    bat_t b;
    iss_t e;
    int p;
    logic first;
    b = '0;
    first = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p = (ref_rot + k) % 3;
      b.slot[k*2 +: 2] = 2'(p + 1);
      if (v[p]) begin
        e.addr  = a[p*AW +: AW];
        e.we    = we[p];
        e.wdata = d[p*DW +: DW];
        e.first = first;
        first   = 1'b0;
        exp_iss.push_back(e);
        if (we[p]) ref_mem[e.addr] = e.wdata;
        else begin
          b.rmask[p] = 1'b1;
          b.rdata[p*DW +: DW] = ref_mem[e.addr];
        end
      end
    end
    ref_rot = (ref_rot + 1) % 3;
    exp_bat.push_back(b);
  endtask

  task automatic drive_ports(input logic [2:0] v, input logic [2:0] we,
                             input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
    {bus.port3_valid_in, bus.port2_valid_in, bus.port1_valid_in} = v;
    {bus.port3_we_in, bus.port2_we_in, bus.port1_we_in} = we;
    {bus.port3_addr_in, bus.port2_addr_in, bus.port1_addr_in} = a;
    {bus.port3_wdata_in, bus.port2_wdata_in, bus.port1_wdata_in} = d;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_returns", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_mem"}, 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    chk({tag, "_slot_ids"}, 32'({bus.slot3_orig_id, bus.slot2_orig_id, bus.slot1_orig_id}), 32'h39);
    chk({tag, "_pulses"}, 32'({bus.batch_done, bus.port3_rvalid_out, bus.port2_rvalid_out, bus.port1_rvalid_out}), 32'd0);
    chk({tag, "_rdata"}, 32'({bus.port3_rdata_out, bus.port2_rdata_out, bus.port1_rdata_out}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_iss.delete();
    exp_bat.delete();
    ref_rot = 0;
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_batch(input logic [2:0] v, input logic [2:0] we,
                           input logic [3*AW-1:0] a, input logic [3*DW-1:0] d, input bit junk);
    wait_ready();
    drive_ports(v, we, a, d);
    push_model(v, we, a, d);
    @(negedge clk);
    if (junk) drive_ports(3'($urandom), 3'($urandom), 18'($urandom), 24'($urandom));
    else      drive_ports(3'b000, 3'b000, '0, '0);
  endtask

  initial begin
    int caps, n, lastc;
    logic [2:0] v;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    drive_ports(3'b000, 3'b000, '0, '0);

    do_reset();
    run_batch(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0, 1'b0);
    run_batch(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0, 1'b0);

    do_reset();
    run_batch(3'b100, 3'b000, {6'd5, 6'd0, 6'd0}, '0, 1'b0);
    run_batch(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0, 1'b0);

    do_reset();
    run_batch(3'b011, 3'b001, {6'd0, 6'd9, 6'd9}, {8'h00, 8'h00, 8'h77}, 1'b0);

    do_reset();
    wait_ready();
    drive_ports(3'b001, 3'b000, {6'd0, 6'd0, 6'd4}, '0);
    caps = 0;
    n = 0;
    lastc = 0;
    while (caps < 4 && n < 100) begin
      if (bus.req_ready) begin
        push_model(3'b001, 3'b000, {6'd0, 6'd0, 6'd4}, '0);
        if (caps > 0) chk("hold_period", 32'(n - lastc), 32'd4);
        lastc = n;
        caps++;
      end
      @(negedge clk);
      n++;
    end
    chk("hold_captures", 32'(caps), 32'd4);
    drive_ports(3'b000, 3'b000, '0, '0);

    for (int t = 0; t < 40; t++) begin
      v = 3'($urandom_range(1, 7));
      run_batch(v, 3'($urandom), {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
                24'($urandom), 1'b1);
    end
    wait_ready();
    drive_ports(3'b000, 3'b000, '0, '0);

    wait_ready();
    drive_ports(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0);
    push_model(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0);
    @(negedge clk);
    drive_ports(3'b000, 3'b000, '0, '0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    exp_iss.delete();
    exp_bat.delete();
    ref_rot = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_batch(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, '0, 1'b0);

    n = 0;
    while (exp_bat.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("all_batches_done", 32'(exp_bat.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tpm_port_sequencer.md
Name: tpm_port_sequencer

Overview:
- Sequences three independent request ports onto one single-ported memory macro.
- Captures a batch of up to three requests and ranks the ports with a rotating round-robin priority. Issues the batch serially in rank order, then returns read data to each request's original port.
- Also drives per-slot original-port IDs, so the existing port deprioritizer path can restore port order for rank-ordered data.

Parameters:
- DATA_W, 8, memory word width.
- ADDR_W, 6, memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- portN_valid_in  in  1  request present, N = 1..3.
- portN_we_in  in  1  1 = write, 0 = read.
- portN_addr_in  in  ADDR_W  request address.
- portN_wdata_in  in  DATA_W  write data.
- req_ready  out  1  high only in IDLE; the batch is captured on an edge where req_ready = 1 and any portN_valid_in = 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after a cycle with mem_en = 1 and mem_we = 0.
- slotK_orig_id  out  2  original port of rank K, K = 1..3, using ORIG_PORT_1/2/3_ID; held for the whole batch.
- portN_rdata_out  out  DATA_W  read result for port N.
- portN_rvalid_out  out  1  one-cycle pulse; port N's read result is available.
- batch_done  out  1  one-cycle pulse at batch completion, for reads and writes alike.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE, rot_ptr = 0.
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - all rdata_out and rvalid_out = 0; batch_done = 0.
  - slot1/2/3_orig_id = ORIG_PORT_1/2/3_ID.
- Ranking:
  - rot_ptr ∈ {0,1,2} selects rank order (ports numbered 0..2 here = port1..port3): rank1 = port(rot_ptr), rank2 = port(rot_ptr+1 mod 3), rank3 = port(rot_ptr+2 mod 3).
  - rot_ptr increments mod 3 (2→0) on every batch completion, whether or not the first-ranked port was valid.
- Capture: on the capture edge, latch valid/we/addr/wdata of all three ports plus the slot IDs; inputs are ignored until IDLE returns.
- States:
  - IDLE → ISSUE on capture.
  - ISSUE: one valid slot issued per cycle in rank order; invalid slots are skipped with no idle cycle. After the last valid slot → DRAIN.
  - DRAIN: one cycle in which the final read data returns → RESP.
  - RESP: one cycle; pulse batch_done and rvalid_out for every captured read port → IDLE.
- Latency:
  - With n valid requests (1..3), mem_en is high for exactly n consecutive cycles, starting the cycle after capture.
  - batch_done and rvalid pulse exactly 2 cycles after the last mem_en cycle.
  - req_ready returns in the cycle after RESP, giving a minimum batch period of n + 3 cycles.
- Read data: mem_rdata is captured into the issuing port's rdata_out register on the cycle after its issue. portN_rdata_out holds its last value until that port's next read. Write-only ports get no rvalid pulse.
- Hazards:
  - Same-address accesses within a batch complete in rank order: a later-ranked write wins.
  - A later-ranked read sees an earlier-ranked write.
- Outside ISSUE, mem_en = 0 and mem_we = 0.
- Reset mid-batch: immediate return to IDLE, batch discarded, no pulses, rot_ptr = 0.

Test Plan:
- Reset, then all three ports read addresses 1, 2, 3 with memory preloaded 0xA1, 0xA2, 0xA3 → mem_addr sequence 1, 2, 3. Two cycles after the last issue, all rvalid pulse together with port1/2/3 rdata = A1/A2/A3. batch_done pulses once; slot IDs = 1, 2, 3.
- Second identical batch → issue order port2, port3, port1 (addresses 2, 3, 1); slot IDs = 2, 3, 1; data still lands on its original port.
- Only port3 valid (read, addr 5 = 0x5C), rot_ptr = 0 → one mem_en cycle to addr 5. port3_rvalid and batch_done pulse 2 cycles later. rot_ptr advances to 1.
- port1 write 0x77 to addr 9, port2 read addr 9, rot_ptr = 0 → port2_rdata = 0x77. No port1 rvalid; batch_done pulses.
- Hold valid high on port1 continuously → captures occur only when req_ready = 1. Batch period for one request = 4 cycles; no duplicate issues.
- Assert rst during the 2nd ISSUE cycle → all outputs return to reset values asynchronously. No rvalid or batch_done pulse; the next batch issues port1 first.
